fuzz_stim_sequencer: RTL



---
 rtl/fuzz_stim_sequencer_if.sv | 41 ++++
 rtl/fuzz_stim_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fuzz_stim_sequencer_if.sv
// fuzz_stim_sequencer_if
// Groups the run-controller handshake and the DUT flat-port bus of the
// stimulus sequencer.
//   master : run controller / DUT side (drives start, abort, seed_in,
//            cycles_in, out_flat; observes everything else)
//   slave  : the sequencer itself
// Signals:
//   start, abort        run request / run termination
//   seed_in, cycles_in  LCG seed and RUN length, latched on start
//   out_flat            DUT flat output vector
//   dut_rst_n, in_flat  DUT reset (active-low) and flat input vector
//   busy, done          run status, done is a one-cycle pulse
//   cyc_count           RUN cycles executed in current/last run
//   signature           MISR signature of all sampled DUT outputs
interface fuzz_stim_sequencer_if #(
  parameter int IN_W  = 132,
  parameter int OUT_W = 159,
  parameter int CNT_W = 32
) ();
  logic             start;
  logic             abort;
  logic [31:0]      seed_in;
  logic [CNT_W-1:0] cycles_in;
  logic [OUT_W-1:0] out_flat;
  logic             dut_rst_n;
  logic [IN_W-1:0]  in_flat;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cyc_count;
  logic [31:0]      signature;

  modport master (
    output start, abort, seed_in, cycles_in, out_flat,
    input  dut_rst_n, in_flat, busy, done, cyc_count, signature
  );

  modport slave (
    input  start, abort, seed_in, cycles_in, out_flat,
    output dut_rst_n, in_flat, busy, done, cyc_count, signature
  );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// fuzz_stim_sequencer
// Hardware stimulus controller: resets the DUT, drives its flat input from a
// 32-bit LCG for a programmable number of cycles and compresses every DUT
// output sample into a 32-bit MISR signature.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fuzz_stim_sequencer_if.slave (run control, status, DUT flat ports)
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last run's results
// RESET  | DUT held in reset for RST_CYCLES cycles
// RUN    | one vector per cycle, DUT output absorbed into the MISR
// DONE   | one-cycle done pulse, then back to IDLE
module fuzz_stim_sequencer #(
  parameter int IN_W       = 132,
  parameter int OUT_W      = 159,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input logic                  clk,
  input logic                  rst,
  fuzz_stim_sequencer_if.slave bus
);
  localparam int NW   = (IN_W + 31) / 32;
  localparam int NO   = (OUT_W + 31) / 32;
  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [31:0] LCG_A = 32'h41C64E6D;
  localparam logic [31:0] LCG_C = 32'h0000_3039;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [31:0]      lcg_state;
  logic [CNT_W-1:0] cycles_lat;
  logic [RC_W-1:0]  rst_cnt;

  logic [31:0]      gen_seed;
  logic [31:0]      gen_last;
  logic [IN_W-1:0]  gen_vec;
  logic [31:0]      fold;
  logic             fb;
  logic [31:0]      sig_next;
  logic [CNT_W-1:0] cyc_next;

  // The first vector of a run is seeded straight from seed_in so it can be
  // presented in the cycle right after start is accepted.
  assign gen_seed = (state == S_IDLE) ? bus.seed_in : lcg_state;

  // NW chained LCG steps in one cycle; the last word is truncated by the
  // shift into the IN_W-wide vector.
  always_comb begin
    gen_last = gen_seed;
    gen_vec  = '0;
    for (int k = 0; k < NW; k++) begin
      gen_last = gen_last * LCG_A + LCG_C;
      gen_vec  = gen_vec | (IN_W'(gen_last) << (32 * k));
    end
  end

  // Top chunk is zero-extended because the shift fills with zeros.
  always_comb begin
    fold = '0;
    for (int k = 0; k < NO; k++) begin
      fold = fold ^ 32'(bus.out_flat >> (32 * k));
    end
  end

  assign fb       = bus.signature[31] ^ bus.signature[21] ^ bus.signature[1] ^ bus.signature[0];
  assign sig_next = {bus.signature[30:0], fb} ^ fold;
  assign cyc_next = bus.cyc_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      lcg_state     <= '0;
      cycles_lat    <= '0;
      rst_cnt       <= '0;
      bus.in_flat   <= '0;
      bus.dut_rst_n <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.cyc_count <= '0;
      bus.signature <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_RESET;
            cycles_lat    <= bus.cycles_in;
            bus.in_flat   <= gen_vec;
            lcg_state     <= gen_last;
            rst_cnt       <= '0;
            bus.cyc_count <= '0;
            bus.signature <= '0;
            bus.dut_rst_n <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end
        S_RESET: begin
          if (bus.abort) begin
            state         <= S_IDLE;
            bus.busy      <= 1'b0;
            bus.dut_rst_n <= 1'b0;
          end else if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            bus.dut_rst_n <= 1'b1;
            if (cycles_lat == '0) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state <= S_RUN;
            end
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_RUN: begin
          // abort wins over completion and discards this edge's update
          if (bus.abort) begin
            state         <= S_IDLE;
            bus.busy      <= 1'b0;
            bus.dut_rst_n <= 1'b0;
          end else begin
            bus.signature <= sig_next;
            bus.cyc_count <= cyc_next;
            bus.in_flat   <= gen_vec;
            lcg_state     <= gen_last;
            if (cyc_next == cycles_lat) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
